// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared widths, opcodes and stream FSM state for the vector datapath blocks
package vec_pkg;

  localparam int LINE_W         = 512;
  localparam int BEAT_W         = 32;
  localparam int BEATS_PER_LINE = LINE_W / BEAT_W;
  localparam int BUF_W          = 2 * LINE_W;
  localparam int IDX_W          = 5;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } stream_state_t;

  // Index of the final beat: one line in narrow mode, two lines in wide mode.
  function automatic logic [IDX_W-1:0] last_idx(input logic wide);
    return wide ? IDX_W'(2 * BEATS_PER_LINE - 1) : IDX_W'(BEATS_PER_LINE - 1);
  endfunction

endpackage

// File: rtl/vec_line_streamer_if.sv
// rtl/vec_line_streamer_if.sv - capture and beat-stream signals of vec_line_streamer
// Optional VEC_STREAM_PARITY_EN adds out_parity.
interface vec_line_streamer_if;
  import vec_pkg::*;

  logic              load_valid;
  logic              load_ready;
  logic              load_wide;
  logic [LINE_W-1:0] load_lo;
  logic [LINE_W-1:0] load_hi;
  logic [BEAT_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [IDX_W-1:0]  out_idx;
`ifdef VEC_STREAM_PARITY_EN
  logic              out_parity;
`endif

  // master: the streamer itself; slave: the capture source plus beat consumer
  modport master (
    input  load_valid, load_wide, load_lo, load_hi, out_ready,
    output load_ready, out_data, out_valid, out_last, out_idx
`ifdef VEC_STREAM_PARITY_EN
    , output out_parity
`endif
  );

  modport slave (
    output load_valid, load_wide, load_lo, load_hi, out_ready,
    input  load_ready, out_data, out_valid, out_last, out_idx
`ifdef VEC_STREAM_PARITY_EN
    , input out_parity
`endif
  );

endinterface

// File: rtl/vec_beat_mux.sv
// rtl/vec_beat_mux.sv - combinational select of one beat-wide word from a double-line buffer
module vec_beat_mux
  import vec_pkg::*;
(
  input  logic [BUF_W-1:0]  data,
  input  logic [IDX_W-1:0]  idx,
  output logic [BEAT_W-1:0] word
);

  localparam int SEL_W = $clog2(BUF_W);

  logic [SEL_W-1:0] base;

  assign base = SEL_W'(idx) * SEL_W'(BEAT_W);
  assign word = data[base +: BEAT_W];

endmodule

// File: rtl/vec_line_streamer.sv
// rtl/vec_line_streamer.sv - captures a 512/1024-bit line and streams it out as 32-bit beats, LSW first
// Optional VEC_STREAM_PARITY_EN drives out_parity = ^out_data.
module vec_line_streamer
  import vec_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  vec_line_streamer_if.master  bus,
  output logic                 busy
);

  stream_state_t     state_q;
  stream_state_t     state_d;
  logic [BUF_W-1:0]  line_q;
  logic              wide_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BEAT_W-1:0] beat_word;
  logic              capture;
  logic              beat_fire;
  logic              last_beat;

  assign capture   = (state_q == IDLE) && bus.load_valid;
  assign beat_fire = (state_q == SEND) && bus.out_ready;
  assign last_beat = (idx_q == last_idx(wide_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.load_valid) state_d = SEND;
      SEND:    if (bus.out_ready && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The high line is masked at capture so unknowns on load_hi never reach the beat path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q <= '0;
      wide_q <= 1'b0;
      idx_q  <= '0;
    end else if (capture) begin
      line_q <= {bus.load_wide ? bus.load_hi : LINE_W'(0), bus.load_lo};
      wide_q <= bus.load_wide;
      idx_q  <= '0;
    end else if (beat_fire) begin
      idx_q  <= last_beat ? '0 : idx_q + 1'b1;
    end
  end

  vec_beat_mux u_beat_mux (
    .data (line_q),
    .idx  (idx_q),
    .word (beat_word)
  );

  always_comb begin
    bus.load_ready = 1'b1;
    bus.out_valid  = 1'b0;
    bus.out_last   = 1'b0;
    bus.out_data   = '0;
    bus.out_idx    = idx_q;
    busy           = 1'b0;
    if (state_q == SEND) begin
      bus.load_ready = 1'b0;
      bus.out_valid  = 1'b1;
      bus.out_last   = last_beat;
      bus.out_data   = beat_word;
      busy           = 1'b1;
    end
  end

`ifdef VEC_STREAM_PARITY_EN
  assign bus.out_parity = ^bus.out_data;
`endif

endmodule

// File: doc/vec_line_streamer.md
Name: vec_line_streamer

Overview:
- Reader/egress counterpart to the 512-bit vector datapath.
- Captures one vector line (512 bits) or one ALU double-width result ({A4,A3}, 1024 bits) in a single cycle.
- Streams the captured data out as 32-bit beats over a valid/ready interface, least-significant word first, in the same word order the vector memory uses (word i = bits [32i+31:32i]).
- Sits between the processor's A1..A4 observation outputs and a narrow 32-bit consumer (debug port, host bus bridge).

Parameters:
- LINE_W, 512, width of one vector line / register.
- BEAT_W, 32, width of one output beat; LINE_W must be an integer multiple of BEAT_W.
- BEATS_PER_LINE, LINE_W/BEAT_W (16), derived; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- load_valid  input  1  capture request.
- load_ready  output  1  block can accept a capture this cycle.
- load_wide  input  1  0 = send lo only (16 beats); 1 = send lo then hi (32 beats).
- load_lo  input  LINE_W  low line (A3 or a register).
- load_hi  input  LINE_W  high line (A4); ignored when load_wide=0.
- out_data  output  BEAT_W  current beat.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the beat.
- out_last  output  1  final beat of the transfer.
- out_idx  output  5  index of the current beat, 0..31.
- busy  output  1  transfer in progress.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; load_ready=1; out_valid=0; out_last=0; out_idx=0; out_data=0; busy=0.
  - Capture buffers cleared to 0.
  - Reset mid-transfer aborts immediately; no further beats are emitted.
- FSM states: IDLE, SEND.
- IDLE:
  - load_ready=1.
  - On load_valid=1: latch {load_hi,load_lo} (hi forced to 0 when load_wide=0), latch load_wide, set idx=0, go to SEND.
- Latency: capture at edge N; the first beat is valid (out_valid=1, out_data=load_lo[31:0]) during cycle N+1.
- SEND:
  - load_ready=0 and busy=1. load_valid is ignored; a request must be held until load_ready returns.
  - out_data = buffer word[idx].
  - Beat handshake: a beat transfers on a rising edge where out_valid=1 and out_ready=1; idx then increments.
  - Stall: with out_ready=0, out_data, out_idx and out_last hold stable, and out_valid stays 1. out_valid never drops before acceptance.
  - out_last=1 when idx == 15 (narrow) or idx == 31 (wide).
  - When the last beat transfers, go to IDLE; out_valid=0 and load_ready=1 in the following cycle. There is no back-to-back capture in the same edge as the last beat, so the minimum gap is 1 idle cycle.
- Wrap: idx never exceeds 31; in narrow mode idx never exceeds 15.
- Arithmetic: counter is 5 bits, unsigned. Beat select is a plain word index; no sign handling. Data is passed bit-exact.
- X/Z on load_hi while load_wide=0 must not propagate; it is masked to 0 at capture.

Optional Feature:
- Macro: VEC_STREAM_PARITY_EN.
- Defined: extra output port out_parity (1 bit), equal to the even parity (XOR-reduce) of out_data. It has the same timing as out_data, is 0 at reset and in IDLE, and holds stable during stalls.
- Undefined: no out_parity port and no parity logic.

Decomposition:
- Shared package vec_pkg:
  - LINE_W=512, BEAT_W=32, BEATS_PER_LINE=16.
  - Opcode constants OP_LOAD=2'b00, OP_STORE=2'b01, OP_ADD=2'b10, OP_MUL=2'b11.
  - State enum for IDLE/SEND.
- One sub-module, vec_beat_mux: combinational 1024-to-32 word select by 5-bit index. It is reusable by the later line-assembler block.
- FSM and counter stay in the top module.

Test Plan:
- Narrow transfer: reset, load_lo=512'd10, load_wide=0, out_ready held 1.
  - Expect 16 beats: beat0=32'd10, beats 1..15=0.
  - out_last only on idx=15; load_ready back to 1 exactly one cycle after the last beat.
- Wide multiply result: load_lo=32'h0000_03E8 in word0, load_hi word0=32'hDEAD_BEEF, load_wide=1.
  - Expect 32 beats: beat0=32'h3E8, beat16=32'hDEADBEEF, out_last at idx=31.
- Backpressure: toggle out_ready 1,0,0,1 each cycle over load_lo = word i = i+1.
  - out_data is stable during the 0 cycles and no beat is skipped or duplicated (sequence 1..16 observed).
- Load while busy: pulse load_valid with load_lo=all-ones mid-transfer of load_lo=512'd2.
  - The remaining beats still come from 512'd2.
  - The new load is accepted only after the transfer finishes and load_ready=1.
- Reset mid-transfer: assert rst_n=0 at beat 7.
  - Next cycle: out_valid=0, busy=0, out_idx=0, load_ready=1.
  - A subsequent load restarts at beat 0.
- VEC_STREAM_PARITY_EN build: beats 32'h1 and 32'h3.
  - out_parity = 1 then 0; the port is absent in the default build.
